return_sequencer: RTL and testbench
===================================

Name: return_sequencer

Overview:
- Sequential controller for the vending-machine total/next-state datapath.
- Owns the inactivity countdown (wait_time) that gates coin acceptance and item purchase in the datapath.
- On timeout or explicit return request, drives o_return_coin one coin per cycle, largest first, until the datapath's current_total is drained.
- Sits beside the current_total register. Its wait_time and o_return_coin outputs feed the datapath's next-state logic directly.

Parameters:
- NUM_COINS, 3, number of coin denominations (matches kNumCoins).
- NUM_ITEMS, 4, number of items (matches kNumItems).
- TOTAL_BITS, 31, width of current_total (matches kTotalBits).
- WAIT_TIME, 100, cycles of inactivity before an automatic return.
- COIN_VAL0 / COIN_VAL1 / COIN_VAL2, 100 / 500 / 1000, coin values. Strictly ascending; index 0 is the smallest.

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- i_input_coin, input, NUM_COINS, coin-insert strobes for this cycle.
- i_output_item, input, NUM_ITEMS, item-dispensed strobes from the datapath for this cycle.
- i_trigger_return, input, 1, user return request (single-cycle pulse or level).
- current_total, input, TOTAL_BITS, present value of the total register.
- wait_time, output, 32, remaining countdown. Datapath accepts coins and purchases only while wait_time > 0.
- o_return_coin, output, NUM_COINS, one-hot coin being returned this cycle, or zero.
- o_returning, output, 1, high while the FSM is in RETURN.

Behaviour:
- Reset (reset_n low, asynchronous, any state including mid-return):
  - State goes to IDLE and wait_time to 0.
  - o_return_coin = 0 and o_returning = 0, both asserted immediately without waiting for a clock edge.
- FSM states: IDLE, WAIT, RETURN. Encoding is free.
- IDLE:
  - wait_time = 0.
  - Any nonzero i_input_coin: next state WAIT, wait_time <= WAIT_TIME.
  - i_trigger_return and i_output_item are ignored.
- WAIT, evaluated in this priority order:
  1. i_trigger_return = 1: next state RETURN, wait_time <= 0. Any coin strobed in the same cycle is still credited by the datapath, because wait_time > 0 in that cycle.
  2. Else, i_input_coin != 0 or i_output_item != 0: wait_time <= WAIT_TIME (reload, no decrement).
  3. Else, wait_time > 1: wait_time <= wait_time - 1.
  4. Else (wait_time == 1): wait_time <= 0, and the next state is RETURN if current_total >= COIN_VAL0, otherwise IDLE.
- RETURN:
  - wait_time held at 0; i_input_coin, i_output_item and i_trigger_return are ignored.
  - o_return_coin is combinational from current_total: one-hot on the highest index k with COIN_VALk <= current_total.
  - Datapath subtracts that coin's value at the same edge, giving exactly one coin per cycle.
  - If current_total < COIN_VAL0, o_return_coin = 0 and the next state is IDLE. Any sub-coin residue stays in the total; this block does not clear it.
- Outside RETURN, o_return_coin = 0 always.
- o_returning = 1 exactly when the state is RETURN.
- Width rules:
  - current_total is compared against the zero-extended coin values.
  - wait_time is 32-bit unsigned and never wraps below 0.
- Return latency: one cycle after the timeout edge or trigger edge, the first coin appears. Drain takes one cycle per returned coin.
- A new coin inserted during RETURN is not credited (wait_time = 0) and does not restart the countdown.

Test Plan:
- Reset mid-RETURN with current_total = 1600, reset_n low asynchronously -> wait_time = 0, o_return_coin = 000, o_returning = 0 without a clock edge; after release, FSM in IDLE.
- WAIT_TIME = 5; insert coin 1000 at cycle 0 -> wait_time 5,4,3,2,1,0 on successive edges; next cycle o_return_coin = 100b; total becomes 0 -> IDLE the following cycle.
- current_total = 1600 in WAIT; pulse i_trigger_return -> o_return_coin = 100b, 010b, 001b on three consecutive cycles; o_returning high for 4 cycles; then IDLE.
- WAIT_TIME = 5, wait_time = 2, insert coin 500 -> wait_time = 5 next cycle. Later, an i_output_item pulse at wait_time = 3 -> wait_time = 5.
- i_trigger_return and coin 100 in the same WAIT cycle with total 500 -> RETURN entered; returned sequence is 500 then 100 (010b, 001b).
- Timeout with current_total = 0 (all spent on items) -> WAIT goes to IDLE directly; o_return_coin never asserted.

Source files
------------

// File: rtl/return_sequencer.sv
// Return sequencer for the vending-machine datapath: owns the inactivity countdown
// and, on timeout or user request, returns coins one per cycle, largest first.
module return_sequencer #(
  parameter int NUM_COINS  = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int TOTAL_BITS = 31,
  parameter int WAIT_TIME  = 100,
  parameter int COIN_VAL0  = 100,
  parameter int COIN_VAL1  = 500,
  parameter int COIN_VAL2  = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_COINS-1:0]  i_input_coin,
  input  logic [NUM_ITEMS-1:0]  i_output_item,
  input  logic                  i_trigger_return,
  input  logic [TOTAL_BITS-1:0] current_total,
  output logic [31:0]           wait_time,
  output logic [NUM_COINS-1:0]  o_return_coin,
  output logic                  o_returning
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RETURN
  } state_t;

  // One extra bit so coin values always compare as zero-extended quantities.
  typedef logic [TOTAL_BITS:0] cmp_t;

  localparam cmp_t        CV0    = cmp_t'(COIN_VAL0);
  localparam cmp_t        CV1    = cmp_t'(COIN_VAL1);
  localparam cmp_t        CV2    = cmp_t'(COIN_VAL2);
  localparam logic [31:0] RELOAD = 32'(WAIT_TIME);

  state_t state;
  cmp_t   total_ext;
  logic   has_coin;
  logic   activity;

  function automatic logic [NUM_COINS-1:0] coin_select(input cmp_t total);
    logic [NUM_COINS-1:0] sel;
    sel = '0;
    if (total >= CV2)      sel[2] = 1'b1;
    else if (total >= CV1) sel[1] = 1'b1;
    else if (total >= CV0) sel[0] = 1'b1;
    return sel;
  endfunction

  assign total_ext = {1'b0, current_total};
  assign has_coin  = (total_ext >= CV0);
  assign activity  = (|i_input_coin) || (|i_output_item);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wait_time <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wait_time <= '0;
          if (|i_input_coin) begin
            state     <= ST_WAIT;
            wait_time <= RELOAD;
          end
        end
        ST_WAIT: begin
          if (i_trigger_return) begin
            state     <= ST_RETURN;
            wait_time <= '0;
          end else if (activity) begin
            wait_time <= RELOAD;
          end else if (wait_time > 32'd1) begin
            wait_time <= wait_time - 32'd1;
          end else begin
            // Countdown expired: only go through RETURN if a whole coin is owed.
            wait_time <= '0;
            state     <= has_coin ? ST_RETURN : ST_IDLE;
          end
        end
        ST_RETURN: begin
          wait_time <= '0;
          if (!has_coin) state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          wait_time <= '0;
        end
      endcase
    end
  end

  // Coin choice follows the total combinationally; the datapath subtracts it the same edge.
  assign o_return_coin = (state == ST_RETURN) ? coin_select(total_ext) : '0;
  assign o_returning   = (state == ST_RETURN);

endmodule

// File: tb/tb_return_sequencer.sv
// Bench for return_sequencer: a small datapath around the DUT, a spec-level model
// compared every cycle, and directed scenarios with literal expectations.
module tb_return_sequencer;
  localparam int WT = 5;
  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_RET  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  i_input_coin;
  logic [3:0]  i_output_item;
  logic        i_trigger_return;
  logic [30:0] current_total;
  logic [31:0] wait_time;
  logic [2:0]  o_return_coin;
  logic        o_returning;

  int checks = 0;
  int errors = 0;
  int cvals[3] = '{100, 500, 1000};
  logic load_en;
  int   load_val;
  int   item_price;
  int   m_mode;
  int   m_wait;

  always #5 clk = ~clk;

  return_sequencer #(.WAIT_TIME(WT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_input_coin(i_input_coin),
    .i_output_item(i_output_item),
    .i_trigger_return(i_trigger_return),
    .current_total(current_total),
    .wait_time(wait_time),
    .o_return_coin(o_return_coin),
    .o_returning(o_returning)
  );

  function automatic int coin_sum(input logic [2:0] c);
    int s = 0;
    for (int k = 0; k < 3; k++) if (c[k]) s += cvals[k];
    return s;
  endfunction

  function automatic logic [2:0] largest_coin(input int t);
    for (int k = 2; k >= 0; k--) if (t >= cvals[k]) return 3'(1 << k);
    return 3'b000;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Datapath stand-in: credits coins unless returning, charges items, subtracts returned coins.
  always @(posedge clk) begin
    if (load_en) current_total <= 31'(load_val);
    else current_total <= 31'(int'(current_total)
                              + (o_returning ? 0 : coin_sum(i_input_coin))
                              - ((i_output_item != 0 && wait_time != 0) ? item_price : 0)
                              - coin_sum(o_return_coin));
  end

  // Behavioural model of the countdown and return mode.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= M_IDLE;
      m_wait <= 0;
    end else if (m_mode == M_IDLE) begin
      if (i_input_coin != 0) begin
        m_mode <= M_WAIT;
        m_wait <= WT;
      end
    end else if (m_mode == M_WAIT) begin
      if (i_trigger_return) begin
        m_mode <= M_RET;
        m_wait <= 0;
      end else if (i_input_coin != 0 || i_output_item != 0) begin
        m_wait <= WT;
      end else if (m_wait > 1) begin
        m_wait <= m_wait - 1;
      end else begin
        m_wait <= 0;
        m_mode <= (int'(current_total) >= cvals[0]) ? M_RET : M_IDLE;
      end
    end else begin
      m_wait <= 0;
      if (int'(current_total) < cvals[0]) m_mode <= M_IDLE;
    end
  end

  always @(negedge clk) begin
    check("model_wait_time", wait_time, m_wait);
    check("model_returning", o_returning, m_mode == M_RET);
    check("model_return_coin", o_return_coin,
          (m_mode == M_RET) ? largest_coin(int'(current_total)) : 3'b000);
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    i_input_coin = '0;
    i_output_item = '0;
    i_trigger_return = 1'b0;
    item_price = 0;
    load_en = 1'b1;
    load_val = 0;
    step();
    step();
    load_en = 1'b0;
    check("rst_wait", wait_time, 0);
    check("rst_returning", o_returning, 0);
    check("rst_coin", o_return_coin, 0);
    reset_n = 1'b1;
    step();

    // Timeout with 1000 in the total
    i_input_coin = 3'b100;
    step();
    i_input_coin = '0;
    check("a_wait_load", wait_time, 5);
    for (int v = 4; v >= 1; v--) begin
      step();
      check("a_countdown", wait_time, v);
    end
    step();
    check("a_wait_zero", wait_time, 0);
    check("a_returning", o_returning, 1);
    check("a_coin", o_return_coin, 3'b100);
    step();
    check("a_drained_coin", o_return_coin, 0);
    check("a_drained_ret", o_returning, 1);
    step();
    check("a_idle", o_returning, 0);

    // Trigger return with 1600
    i_input_coin = 3'b100; step();
    i_input_coin = 3'b010; step();
    i_input_coin = 3'b001; step();
    i_input_coin = '0;
    check("b_total", current_total, 1600);
    i_trigger_return = 1'b1; step();
    i_trigger_return = 1'b0;
    check("b_coin0", o_return_coin, 3'b100);
    step(); check("b_coin1", o_return_coin, 3'b010);
    step(); check("b_coin2", o_return_coin, 3'b001);
    step(); check("b_ret4", o_returning, 1); check("b_coin3", o_return_coin, 0);
    step(); check("b_idle", o_returning, 0); check("b_total_end", current_total, 0);

    // Reload on coin and on item
    i_input_coin = 3'b001; step();
    i_input_coin = '0;
    step(); step(); step();
    check("c_wait2", wait_time, 2);
    i_input_coin = 3'b010; step();
    i_input_coin = '0;
    check("c_reload_coin", wait_time, 5);
    step(); step();
    check("c_wait3", wait_time, 3);
    i_output_item = 4'b0001; item_price = 100; step();
    i_output_item = '0;
    check("c_reload_item", wait_time, 5);
    i_trigger_return = 1'b1; step();
    i_trigger_return = 1'b0;
    check("c_coin", o_return_coin, 3'b010);
    step(); step();
    check("c_idle", o_returning, 0);

    // Trigger and coin in the same cycle
    i_input_coin = 3'b010; step();
    i_input_coin = 3'b001; i_trigger_return = 1'b1; step();
    i_input_coin = '0; i_trigger_return = 1'b0;
    check("d_total", current_total, 600);
    check("d_coin0", o_return_coin, 3'b010);
    step(); check("d_coin1", o_return_coin, 3'b001);
    step(); check("d_ret", o_returning, 1);
    step(); check("d_idle", o_returning, 0);

    // Timeout with nothing left
    i_input_coin = 3'b001; step();
    i_input_coin = '0;
    i_output_item = 4'b0010; item_price = 100; step();
    i_output_item = '0;
    check("e_total", current_total, 0);
    for (int v = 4; v >= 1; v--) begin
      step();
      check("e_countdown", wait_time, v);
    end
    step();
    check("e_wait0", wait_time, 0);
    check("e_noret", o_returning, 0);
    step();
    check("e_still_idle", o_returning, 0);
    check("e_coin", o_return_coin, 0);

    // Asynchronous reset mid-return
    i_input_coin = 3'b100; step();
    i_input_coin = 3'b010; step();
    i_input_coin = 3'b001; step();
    i_input_coin = '0;
    i_trigger_return = 1'b1; step();
    i_trigger_return = 1'b0;
    check("f_ret", o_returning, 1);
    check("f_coin", o_return_coin, 3'b100);
    #2 reset_n = 1'b0;
    #1;
    check("f_async_wait", wait_time, 0);
    check("f_async_coin", o_return_coin, 0);
    check("f_async_ret", o_returning, 0);
    step();
    reset_n = 1'b1;
    step();
    check("f_idle_ret", o_returning, 0);
    check("f_idle_wait", wait_time, 0);
    check("f_total_kept", current_total, 1600);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
